// File: rtl/fir_pkg.sv
// fir_pkg: shared widths and the round/shift/saturate helper for the FIR output requantiser
package fir_pkg;
    localparam int FIR_IN_WIDTH  = 32;
    localparam int FIR_OUT_WIDTH = 16;
    localparam int FIR_SHW       = 5;
    localparam int FIR_DW        = 8;
    typedef struct packed {
        logic                     sat;
        logic [FIR_OUT_WIDTH-1:0] data;
    } rq_t;
    // Round half up, arithmetic shift right, clamp to the signed output range.
    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic rq_t sat_round(input logic [FIR_IN_WIDTH-1:0] data, input logic [FIR_SHW-1:0] shift);
        logic        [FIR_IN_WIDTH:0]               rnd;
        logic signed [FIR_IN_WIDTH:0]               r;
        logic signed [FIR_IN_WIDTH:0]               q;
        logic        [FIR_IN_WIDTH:FIR_OUT_WIDTH-1] hi;
        rq_t                                        res;
        rnd = (shift == '0) ? '0 : ({{FIR_IN_WIDTH{1'b0}}, 1'b1} << (shift - 1'b1));
        r = $signed({data[FIR_IN_WIDTH-1], data}) + $signed(rnd);
        q = r >>> shift;
        hi = q[FIR_IN_WIDTH:FIR_OUT_WIDTH-1];
        res.sat = !((&hi) || !(|hi));
        res.data = res.sat ? {q[FIR_IN_WIDTH], {(FIR_OUT_WIDTH-1){~q[FIR_IN_WIDTH]}}} : q[FIR_OUT_WIDTH-1:0];
        return res;
    endfunction
endpackage

// File: rtl/fir_out_requant_skid.sv
// axis_skid2: 2-entry AXI-Stream skid register (output register plus one skid slot)
//  axis_clk, axis_rst   clock, async active-high reset
//  in_data/valid/ready  upstream side; in_ready is registered and equals !skid_valid
//  out_data/valid/ready downstream side; out_data held while out_valid && !out_ready
module axis_skid2 #(
    parameter int WIDTH = 17
) (
    input  logic             axis_clk,
    input  logic             axis_rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             push;
    logic             load_out;
    logic             skid_valid_n;
    always_comb begin
        push = in_valid && in_ready;
        load_out = !out_valid || out_ready;
        skid_valid_n = load_out ? 1'b0 : (skid_valid || push);
    end
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            skid_data <= '0;
            skid_valid <= 1'b0;
            in_ready <= 1'b0;
            out_data <= '0;
            out_valid <= 1'b0;
        end else begin
            skid_valid <= skid_valid_n;
            in_ready <= !skid_valid_n;
            if (load_out) begin
                out_valid <= skid_valid || push;
                if (skid_valid)
                    out_data <= skid_data;
                else if (push)
                    out_data <= in_data;
            end
            if (!load_out && push)
                skid_data <= in_data;
        end
    end
endmodule

// File: rtl/fir_out_requant.sv
// fir_out_requant: round, shift, saturate and decimate the FIR AXI-Stream output
//  axis_clk, axis_rst            clock, async active-high reset
//  ss_tdata/tvalid/tlast/tready  wide input stream from the FIR
//  sm_tdata/tvalid/tlast/tready  narrow requantised output stream
//  cfg_shift, cfg_decim          captured on the first beat of each frame
//  sat_cnt                       saturated kept samples, sticky at 16'hFFFF
//  frame_done                    pulse the cycle after the sm_tlast beat is taken
module fir_out_requant
    import fir_pkg::*;
#(
    parameter int IN_WIDTH  = FIR_IN_WIDTH,
    parameter int OUT_WIDTH = FIR_OUT_WIDTH,
    parameter int SHW       = FIR_SHW,
    parameter int DW        = FIR_DW
) (
    input  logic                 axis_clk,
    input  logic                 axis_rst,
    input  logic [IN_WIDTH-1:0]  ss_tdata,
    input  logic                 ss_tvalid,
    input  logic                 ss_tlast,
    output logic                 ss_tready,
    output logic [OUT_WIDTH-1:0] sm_tdata,
    output logic                 sm_tvalid,
    output logic                 sm_tlast,
    input  logic                 sm_tready,
    input  logic [SHW-1:0]       cfg_shift,
    input  logic [DW-1:0]        cfg_decim,
    output logic [15:0]          sat_cnt,
    output logic                 frame_done
);
    logic             first;
    logic [SHW-1:0]   shift_q;
    logic [DW-1:0]    decim_q;
    logic [DW-1:0]    phase;
    logic             accept;
    logic             keep;
    logic [SHW-1:0]   shift;
    logic [DW-1:0]    decim;
    logic [DW-1:0]    last_phase;
    rq_t              rq;
    logic [OUT_WIDTH:0] out_word;
    // The first beat of a frame uses the live config; the rest use the captured copy.
    always_comb begin
        accept = ss_tvalid && ss_tready;
        shift = first ? cfg_shift : shift_q;
        decim = first ? cfg_decim : decim_q;
        last_phase = (decim == '0) ? '0 : decim - 1'b1;
        keep = accept && (phase == '0 || ss_tlast);
        rq = sat_round(ss_tdata, shift);
    end
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            first <= 1'b1;
            shift_q <= '0;
            decim_q <= '0;
            phase <= '0;
            sat_cnt <= '0;
            frame_done <= 1'b0;
        end else begin
            if (accept) begin
                first <= ss_tlast;
                phase <= (ss_tlast || phase >= last_phase) ? '0 : phase + 1'b1;
                if (first) begin
                    shift_q <= cfg_shift;
                    decim_q <= cfg_decim;
                end
            end
            if (keep && rq.sat && sat_cnt != 16'hFFFF)
                sat_cnt <= sat_cnt + 1'b1;
            frame_done <= sm_tvalid && sm_tready && sm_tlast;
        end
    end
    axis_skid2 #(.WIDTH(OUT_WIDTH + 1)) u_skid (
        .axis_clk  (axis_clk),
        .axis_rst  (axis_rst),
        .in_data   ({ss_tlast, rq.data}),
        .in_valid  (keep),
        .in_ready  (ss_tready),
        .out_data  (out_word),
        .out_valid (sm_tvalid),
        .out_ready (sm_tready)
    );
    assign sm_tlast = out_word[OUT_WIDTH];
    assign sm_tdata = out_word[OUT_WIDTH-1:0];
endmodule

// File: tb/tb_fir_out_requant.sv
// tb_fir_out_requant: directed self-checking bench for fir_out_requant
module tb_fir_out_requant;
    logic        axis_clk = 1'b0;
    logic        axis_rst = 1'b1;
    logic [31:0] ss_tdata = '0;
    logic        ss_tvalid = 1'b0;
    logic        ss_tlast = 1'b0;
    logic        ss_tready;
    logic [15:0] sm_tdata;
    logic        sm_tvalid;
    logic        sm_tlast;
    logic        sm_tready = 1'b1;
    logic [4:0]  cfg_shift = '0;
    logic [7:0]  cfg_decim = 8'd1;
    logic [15:0] sat_cnt;
    logic        frame_done;
    int          evals = 0;
    int          fails = 0;
    int          fd_cnt = 0;
    int          fd0;
    bit          done;
    logic [16:0] q[$];
    logic [16:0] exp_q[$];

    fir_out_requant dut (
        .axis_clk   (axis_clk),
        .axis_rst   (axis_rst),
        .ss_tdata   (ss_tdata),
        .ss_tvalid  (ss_tvalid),
        .ss_tlast   (ss_tlast),
        .ss_tready  (ss_tready),
        .sm_tdata   (sm_tdata),
        .sm_tvalid  (sm_tvalid),
        .sm_tlast   (sm_tlast),
        .sm_tready  (sm_tready),
        .cfg_shift  (cfg_shift),
        .cfg_decim  (cfg_decim),
        .sat_cnt    (sat_cnt),
        .frame_done (frame_done)
    );

    always #5 axis_clk = ~axis_clk;

    always @(negedge axis_clk) begin
        if (sm_tvalid && sm_tready && !axis_rst)
            q.push_back({sm_tlast, sm_tdata});
        if (frame_done)
            fd_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        evals++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] ent(input int i);
        return (i < q.size()) ? q[i] : 17'bx;
    endfunction

    task automatic ex(input logic [15:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_len"}, q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), {15'd0, ent(i)}, {15'd0, exp_q[i]});
        q.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int t = 0;
        ss_tdata = d;
        ss_tlast = l;
        ss_tvalid = 1'b1;
        while (!ss_tready && t < 200) begin
            @(posedge axis_clk);
            #1;
            t++;
        end
        if (!ss_tready) begin
            evals++;
            fails++;
            $display("FAIL send_timeout: ss_tready stuck low, data %0h", d);
        end
        @(posedge axis_clk);
        #1;
        ss_tvalid = 1'b0;
        ss_tlast = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sm_tvalid && t < 5000) begin
            @(posedge axis_clk);
            #1;
            t++;
        end
        if (sm_tvalid) begin
            evals++;
            fails++;
            $display("FAIL drain_timeout: sm_tvalid stuck high");
        end
        repeat (2) begin
            @(posedge axis_clk);
            #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge axis_clk);
        #1;
        check("rst_ss_tready", ss_tready, 0);
        check("rst_sm_tvalid", sm_tvalid, 0);
        check("rst_sm_tlast", sm_tlast, 0);
        check("rst_sm_tdata", sm_tdata, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_frame_done", frame_done, 0);
        axis_rst = 1'b0;
        @(posedge axis_clk);
        #1;
        check("ready_after_rst", ss_tready, 1);

        // 1: saturation at shift 0
        fd0 = fd_cnt;
        send(32'd100, 1'b0);
        check("t1_latency_valid", sm_tvalid, 1);
        check("t1_latency_data", sm_tdata, 16'd100);
        send(-32'sd5, 1'b0);
        send(32'd32767, 1'b0);
        send(32'd32768, 1'b0);
        send(-32'sd32769, 1'b1);
        drain();
        ex(16'd100, 0); ex(16'hFFFB, 0); ex(16'h7FFF, 0); ex(16'h7FFF, 0); ex(16'h8000, 1);
        check_frame("t1");
        check("t1_sat_cnt", sat_cnt, 2);
        check("t1_frame_done", fd_cnt - fd0, 1);

        // 2: rounding with shift 4
        cfg_shift = 5'd4;
        send(32'd24, 1'b0);
        send(-32'sd24, 1'b0);
        send(32'd23, 1'b0);
        send(-32'sd8, 1'b1);
        drain();
        ex(16'd2, 0); ex(16'hFFFF, 0); ex(16'd1, 0); ex(16'd0, 1);
        check_frame("t2");
        check("t2_sat_cnt", sat_cnt, 2);

        // skid fill with a stalled consumer
        cfg_shift = 5'd0;
        sm_tready = 1'b0;
        send(32'd1, 1'b0);
        send(32'd2, 1'b1);
        check("skid_ready_low", ss_tready, 0);
        check("skid_out_valid", sm_tvalid, 1);
        check("skid_out_data", sm_tdata, 1);
        @(posedge axis_clk);
        #1;
        check("skid_hold_data", sm_tdata, 1);
        check("skid_hold_last", sm_tlast, 0);
        sm_tready = 1'b1;
        drain();
        ex(16'd1, 0); ex(16'd2, 1);
        check_frame("skid");

        // 3: decimate by 3, tlast always kept
        cfg_decim = 8'd3;
        fd0 = fd_cnt;
        for (int i = 0; i < 10; i++)
            send(i, i == 9);
        drain();
        ex(16'd0, 0); ex(16'd3, 0); ex(16'd6, 0); ex(16'd9, 1);
        check_frame("t3");
        check("t3_frame_done", fd_cnt - fd0, 1);

        // 4: 600 beats with sm_tready pattern 1-0-0-1
        cfg_decim = 8'd1;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 600; i++)
                    send(i, i == 599);
                done = 1'b1;
            end
            begin
                int c = 0;
                while (!(done && !sm_tvalid) && c < 5000) begin
                    @(posedge axis_clk);
                    #1;
                    sm_tready = (c % 4 == 0) || (c % 4 == 3);
                    c++;
                end
                sm_tready = 1'b1;
            end
        join
        drain();
        begin
            int mism = 0;
            for (int i = 0; i < 600; i++)
                if (ent(i) !== {i == 599, 16'(i)})
                    mism++;
            check("t4_len", q.size(), 600);
            check("t4_order_mismatches", mism, 0);
        end
        q.delete();

        // 5: decim change mid-frame is deferred to the next frame
        cfg_decim = 8'd2;
        for (int i = 0; i < 10; i++) begin
            if (i == 4)
                cfg_decim = 8'd5;
            send(i, i == 9);
        end
        drain();
        ex(16'd0, 0); ex(16'd2, 0); ex(16'd4, 0); ex(16'd6, 0); ex(16'd8, 0); ex(16'd9, 1);
        check_frame("t5a");
        for (int i = 0; i < 10; i++)
            send(i, i == 9);
        drain();
        ex(16'd0, 0); ex(16'd5, 0); ex(16'd9, 1);
        check_frame("t5b");

        // 6: reset after 7 of 11 beats
        cfg_decim = 8'd1;
        for (int i = 0; i < 7; i++)
            send(32'd40000, 1'b0);
        check("t6_pre_sat_cnt", sat_cnt, 9);
        check("t6_pre_valid", sm_tvalid, 1);
        axis_rst = 1'b1;
        #1;
        check("t6_rst_valid", sm_tvalid, 0);
        check("t6_rst_sat_cnt", sat_cnt, 0);
        check("t6_rst_ready", ss_tready, 0);
        @(posedge axis_clk);
        #1;
        axis_rst = 1'b0;
        q.delete();
        fd0 = fd_cnt;
        for (int i = 0; i < 11; i++)
            send(i, i == 10);
        drain();
        for (int i = 0; i < 11; i++)
            ex(16'(i), i == 10);
        check_frame("t6");
        check("t6_sat_cnt", sat_cnt, 0);
        check("t6_frame_done", fd_cnt - fd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end
endmodule
